afe_frame_collector: RTL and testbench
======================================

Name: afe_frame_collector

Overview:
- Parametrised successor to the AFE sample-buffer stage. It walks the AFE result RAM one channel at a time and gathers NUM_CH channel words into a shadow bank. It then publishes all channels atomically with a frame-valid strobe and a decimated-valid strobe.
- It also runs the diagnostic read/decode sequence.
- Sits between the RAM address-select logic and the downstream FIFO/UART/NIOS consumers.

Parameters:
- NUM_CH, 6, number of channel words per frame. Channel i is read from address CH_BASE+i.
- CH_BASE, 0, RAM address of channel 0.
- DATA_W, 22, captured bits per channel (in_strm_data[DATA_W-1:0]).
- ADDR_W, 3, RAM address width.
- RD_LAT, 2, cycles each address is held. Data is sampled on the last held cycle (1..8).
- DIAG_ADDR, 6, RAM address of the diagnostic word.
- VALID_HOLD, 2, cycles out_frame_valid stays high (for half-rate consumers).
- DECIM, 13, out_decim_valid fires on every DECIM-th published frame.

Ports:
- clk, in, 1, system clock.
- in_reset, in, 1, synchronous active-high reset.
- in_mode, in, 2, 00 idle, 01 diagnostic, 10 stream, 11 treated as 00.
- in_strm_dn, in, 1, AFE conversion complete; frame request.
- in_strm_data, in, 24, RAM read data.
- out_addr, out, ADDR_W, registered RAM read address.
- out_ch_data, out, NUM_CH*DATA_W, published channels; channel i occupies bits [i*DATA_W +: DATA_W].
- out_frame_valid, out, 1, publish strobe, high VALID_HOLD cycles.
- out_decim_valid, out, 1, high together with out_frame_valid on decimated frames.
- out_overrun, out, 1, sticky: a frame request arrived while busy.
- out_er_data, out, 14, captured diagnostic bits in_strm_data[13:0].
- out_diag_er, out, 2, 00 pending, 10 no error, 01 error.

Behaviour:
- Reset (in_reset=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including out_ch_data, the shadow bank, the decimation counter and the overrun flag.
  - Reset overrides every other input.
- States: IDLE, WAIT_DN, FETCH, PUBLISH, DIAG_RD, DIAG_DONE.
- Mode 00/11:
  - Forces IDLE from any state on the next edge.
  - Clears out_addr, out_er_data, out_diag_er, out_overrun, the decimation counter and both valids.
  - out_ch_data is held.
- IDLE transitions:
  - In mode 10, go to WAIT_DN.
  - In mode 01, go to DIAG_RD with out_addr<=DIAG_ADDR and the hold counter at 0.
- WAIT_DN:
  - On in_strm_dn=1, go to FETCH with out_addr<=CH_BASE, ch=0, hold=0.
  - Otherwise stay, with out_addr held.
- FETCH:
  - Each cycle increments hold.
  - When hold==RD_LAT-1: shadow[ch]<=in_strm_data[DATA_W-1:0] and hold<=0.
  - If ch<NUM_CH-1: ch++ and out_addr<=CH_BASE+ch+1.
  - Otherwise go to PUBLISH.
- PUBLISH:
  - First cycle: out_ch_data<=shadow (all channels at once), out_frame_valid<=1, and out_decim_valid<=1 iff decim_cnt==DECIM-1.
  - decim_cnt wraps DECIM-1 -> 0; otherwise it increments.
  - Valids stay high for exactly VALID_HOLD cycles, then drop, and the state returns to WAIT_DN.
- Latency:
  - First FETCH capture happens RD_LAT cycles after the in_strm_dn edge.
  - out_frame_valid first goes high NUM_CH*RD_LAT+1 edges after the in_strm_dn edge.
  - Default: 13 edges.
- Overrun:
  - in_strm_dn=1 while in FETCH or PUBLISH sets out_overrun=1 (sticky until mode 00 or reset).
  - The request is dropped; no queued frame.
  - in_strm_dn on the very edge PUBLISH exits is also dropped; WAIT_DN only samples on its own cycles.
- Mode change during a frame:
  - 10 -> 01 mid-FETCH/PUBLISH aborts the frame: no publish, out_ch_data unchanged, valids forced low.
  - The state goes to IDLE and then follows the IDLE transitions.
- DIAG_RD:
  - Wait RD_LAT cycles.
  - On hold==RD_LAT-1: out_er_data<=in_strm_data[13:0] and er<=|in_strm_data[13:0], then go to DIAG_DONE.
- DIAG_DONE:
  - out_diag_er<= er ? 01 : 10, held while mode stays 01.
  - Leaving mode 01 goes to IDLE.
- Width rules:
  - in_strm_data bits above DATA_W-1 are ignored; no sign extension is done here.
  - out_addr is CH_BASE+ch truncated to ADDR_W. Elaboration must check CH_BASE+NUM_CH-1 < 2^ADDR_W.
- Counters: ch is clog2(NUM_CH) bits; hold is clog2(RD_LAT)+1 bits; decim_cnt is clog2(DECIM)+1 bits.

Decomposition:
- Shared package afe_pkg holds:
  - the mode encodings (MODE_IDLE=2'b00, MODE_DIAG=2'b01, MODE_STREAM=2'b10);
  - the diag codes (DIAG_PEND=00, DIAG_OK=10, DIAG_ERR=01);
  - the FSM state enum;
  - DIAG_BITS=14 and RAM_DATA_W=24.
- One natural sub-module, afe_decim_counter: a modulo-DECIM counter with an increment enable, synchronous clear and a terminal-count output. It is reused by the UART path.

Test Plan:
1. Reset check: hold in_reset=1 for 3 cycles with in_mode=10 and in_strm_dn=1 -> all outputs 0, and the state stays IDLE during reset.
2. Single frame (defaults): mode 10, in_strm_data=0xA0_0000+out_addr, pulse in_strm_dn -> out_addr steps 0..5 for 2 cycles each. out_frame_valid is high on edges 13-14 after the pulse, and channel i = 0x200000+i (22-bit truncation).
3. Decimation: 26 back-to-back frames -> out_decim_valid high only on frames 13 and 26; 24 frame strobes have it low.
4. Overrun: in_strm_dn pulsed again 4 cycles into FETCH -> out_overrun=1, exactly one publish. Switching to mode 00 clears out_overrun to 0.
5. Diagnostics: mode 01 with RAM[6]=0x000000 -> out_er_data=0, out_diag_er=10 after RAM read. A rerun with RAM[6]=0x002001 -> out_er_data=0x2001, out_diag_er=01.
6. Abort: mode 10 -> 01 at the third FETCH capture -> no out_frame_valid, out_ch_data keeps the previous frame, and the diag sequence completes normally.

Source files
------------

// File: rtl/afe_pkg.sv
// rtl/afe_pkg.sv - shared AFE mode/diag encodings and collector FSM states
package afe_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_DIAG   = 2'b01;
  localparam logic [1:0] MODE_STREAM = 2'b10;

  localparam logic [1:0] DIAG_PEND = 2'b00;
  localparam logic [1:0] DIAG_OK   = 2'b10;
  localparam logic [1:0] DIAG_ERR  = 2'b01;

  localparam int DIAG_BITS  = 14;
  localparam int RAM_DATA_W = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DN,
    S_FETCH,
    S_PUBLISH,
    S_DIAG_RD,
    S_DIAG_DONE
  } afe_state_t;

  // Mode 11 is reserved and behaves exactly like idle.
  function automatic logic is_idle_mode(input logic [1:0] mode);
    return (mode == MODE_IDLE) || (mode == 2'b11);
  endfunction

endpackage

// File: rtl/afe_decim_counter.sv
// rtl/afe_decim_counter.sv - modulo-DECIM event counter with terminal-count flag
module afe_decim_counter #(
  parameter int DECIM = 13,
  parameter int CNT_W = $clog2(DECIM) + 1
) (
  input  logic             clk,
  input  logic             in_reset,
  input  logic             in_clr,
  input  logic             in_inc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_tc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  // Terminal count reflects the current value, so the event that wraps is the flagged one.
  assign out_tc = (out_cnt == CNT_LAST);

  // Count enabled events, wrapping DECIM-1 back to zero; clear wins over increment.
  always_ff @(posedge clk) begin
    if (in_reset || in_clr) begin
      out_cnt <= '0;
    end else if (in_inc) begin
      out_cnt <= out_tc ? '0 : out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/afe_frame_collector.sv
// rtl/afe_frame_collector.sv - gathers AFE channel words into a shadow bank and publishes them atomically
module afe_frame_collector
  import afe_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int CH_BASE    = 0,
  parameter int DATA_W     = 22,
  parameter int ADDR_W     = 3,
  parameter int RD_LAT     = 2,
  parameter int DIAG_ADDR  = 6,
  parameter int VALID_HOLD = 2,
  parameter int DECIM      = 13
) (
  input  logic                     clk,
  input  logic                     in_reset,
  input  logic [1:0]               in_mode,
  input  logic                     in_strm_dn,
  input  logic [RAM_DATA_W-1:0]    in_strm_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [NUM_CH*DATA_W-1:0] out_ch_data,
  output logic                     out_frame_valid,
  output logic                     out_decim_valid,
  output logic                     out_overrun,
  output logic [DIAG_BITS-1:0]     out_er_data,
  output logic [1:0]               out_diag_er
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W = $clog2(RD_LAT) + 1;
  localparam int VCNT_W = $clog2(VALID_HOLD + 1);
  localparam int DEC_W  = $clog2(DECIM) + 1;

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RD_LAT - 1);
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(VALID_HOLD);

  if (CH_BASE + NUM_CH - 1 >= (1 << ADDR_W)) begin : g_bad_addr
    $error("afe_frame_collector: channel addresses do not fit in ADDR_W");
  end
  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_lat
    $error("afe_frame_collector: RD_LAT must be 1..8");
  end

  afe_state_t state, state_d;

  logic [CH_W-1:0]          ch;
  logic [HOLD_W-1:0]        hold;
  logic [VCNT_W-1:0]        vcnt;
  logic [NUM_CH*DATA_W-1:0] shadow;
  logic                     er;
  logic [DEC_W-1:0]         decim_cnt;
  logic                     decim_tc;

  logic mode_clr, abort, diag_start, fetch_start, fetch_cap, diag_cap, pub_first, pub_last;

  logic unused_ok;
  assign unused_ok = ^{in_strm_data, decim_cnt};

  afe_decim_counter #(
    .DECIM (DECIM),
    .CNT_W (DEC_W)
  ) u_decim (
    .clk      (clk),
    .in_reset (in_reset),
    .in_clr   (mode_clr),
    .in_inc   (pub_first),
    .out_cnt  (decim_cnt),
    .out_tc   (decim_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (in_reset) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next state and per-cycle control strobes; a mode that does not match the running sequence drops to IDLE.
  always_comb begin
    state_d     = state;
    mode_clr    = 1'b0;
    abort       = 1'b0;
    diag_start  = 1'b0;
    fetch_start = 1'b0;
    fetch_cap   = 1'b0;
    diag_cap    = 1'b0;
    pub_first   = 1'b0;
    pub_last    = 1'b0;
    if (is_idle_mode(in_mode)) begin
      state_d  = S_IDLE;
      mode_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_mode == MODE_STREAM) begin
            state_d = S_WAIT_DN;
          end else begin
            state_d    = S_DIAG_RD;
            diag_start = 1'b1;
          end
        end
        S_WAIT_DN: begin
          if (in_mode != MODE_STREAM) begin
            state_d = S_IDLE;
          end else if (in_strm_dn) begin
            state_d     = S_FETCH;
            fetch_start = 1'b1;
          end
        end
        S_FETCH: begin
          if (in_mode != MODE_STREAM) begin
            state_d = S_IDLE;
            abort   = 1'b1;
          end else if (hold == HOLD_LAST) begin
            fetch_cap = 1'b1;
            if (ch == CH_LAST) state_d = S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          if (in_mode != MODE_STREAM) begin
            state_d = S_IDLE;
            abort   = 1'b1;
          end else begin
            pub_first = (vcnt == '0);
            if (vcnt == VCNT_LAST) begin
              pub_last = 1'b1;
              state_d  = S_WAIT_DN;
            end
          end
        end
        S_DIAG_RD: begin
          if (in_mode != MODE_DIAG) begin
            state_d = S_IDLE;
          end else if (hold == HOLD_LAST) begin
            diag_cap = 1'b1;
            state_d  = S_DIAG_DONE;
          end
        end
        S_DIAG_DONE: begin
          if (in_mode != MODE_DIAG) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Address sequencing, shadow capture, atomic publish and diagnostic capture.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      out_addr        <= '0;
      out_ch_data     <= '0;
      out_frame_valid <= 1'b0;
      out_decim_valid <= 1'b0;
      out_overrun     <= 1'b0;
      out_er_data     <= '0;
      out_diag_er     <= DIAG_PEND;
      shadow          <= '0;
      ch              <= '0;
      hold            <= '0;
      vcnt            <= '0;
      er              <= 1'b0;
    end else if (mode_clr) begin
      out_addr        <= '0;
      out_frame_valid <= 1'b0;
      out_decim_valid <= 1'b0;
      out_overrun     <= 1'b0;
      out_er_data     <= '0;
      out_diag_er     <= DIAG_PEND;
    end else begin
      if (abort) begin
        out_frame_valid <= 1'b0;
        out_decim_valid <= 1'b0;
      end
      // A request while a frame is in flight is dropped, only flagged.
      if ((state == S_FETCH || state == S_PUBLISH) && in_strm_dn) out_overrun <= 1'b1;
      if (diag_start) begin
        out_addr    <= ADDR_W'(DIAG_ADDR);
        hold        <= '0;
        out_diag_er <= DIAG_PEND;
      end
      if (fetch_start) begin
        out_addr <= ADDR_W'(CH_BASE);
        ch       <= '0;
        hold     <= '0;
        vcnt     <= '0;
      end
      if (state == S_FETCH && !abort) begin
        if (fetch_cap) begin
          shadow[int'(ch)*DATA_W +: DATA_W] <= in_strm_data[DATA_W-1:0];
          hold <= '0;
          if (ch != CH_LAST) begin
            ch       <= ch + CH_W'(1);
            out_addr <= ADDR_W'(CH_BASE + int'(ch) + 1);
          end
        end else begin
          hold <= hold + HOLD_W'(1);
        end
      end
      if (state == S_PUBLISH && !abort) begin
        if (pub_first) begin
          out_ch_data     <= shadow;
          out_frame_valid <= 1'b1;
          out_decim_valid <= decim_tc;
        end
        if (pub_last) begin
          out_frame_valid <= 1'b0;
          out_decim_valid <= 1'b0;
          vcnt            <= '0;
        end else begin
          vcnt <= vcnt + VCNT_W'(1);
        end
      end
      if (state == S_DIAG_RD && in_mode == MODE_DIAG) begin
        if (diag_cap) begin
          out_er_data <= in_strm_data[DIAG_BITS-1:0];
          er          <= |in_strm_data[DIAG_BITS-1:0];
          hold        <= '0;
        end else begin
          hold <= hold + HOLD_W'(1);
        end
      end
      if (state == S_DIAG_DONE && in_mode == MODE_DIAG) begin
        out_diag_er <= er ? DIAG_ERR : DIAG_OK;
      end
    end
  end

endmodule

// File: tb/tb_afe_frame_collector.sv
// tb/tb_afe_frame_collector.sv - scoreboard bench for afe_frame_collector
module tb_afe_frame_collector;
  import afe_pkg::*;

  localparam int NUM_CH     = 6;
  localparam int CH_BASE    = 0;
  localparam int DATA_W     = 22;
  localparam int ADDR_W     = 3;
  localparam int RD_LAT     = 2;
  localparam int DIAG_ADDR  = 6;
  localparam int VALID_HOLD = 2;
  localparam int DECIM      = 13;
  localparam int FW         = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              in_reset;
  logic [1:0]        in_mode;
  logic              in_strm_dn;
  logic [23:0]       in_strm_data;
  logic [ADDR_W-1:0] out_addr;
  logic [FW-1:0]     out_ch_data;
  logic              out_frame_valid;
  logic              out_decim_valid;
  logic              out_overrun;
  logic [13:0]       out_er_data;
  logic [1:0]        out_diag_er;

  logic [23:0] ram_seed  = 24'h0;
  logic [23:0] ram_step  = 24'h0;
  logic [23:0] diag_word = 24'h0;

  typedef struct {
    logic [FW-1:0] data;
    logic          decim;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_decim_cnt = 0;
  int            n_pub = 0;
  int            n_dec_hi = 0;
  int            n_dec_lo = 0;
  int            vlen = 0;
  int            pub0;
  logic          prev_valid = 1'b0;
  logic [FW-1:0] last_exp = '0;
  logic [FW-1:0] single_exp;

  afe_frame_collector #(
    .NUM_CH     (NUM_CH),
    .CH_BASE    (CH_BASE),
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .RD_LAT     (RD_LAT),
    .DIAG_ADDR  (DIAG_ADDR),
    .VALID_HOLD (VALID_HOLD),
    .DECIM      (DECIM)
  ) dut (
    .clk             (clk),
    .in_reset        (in_reset),
    .in_mode         (in_mode),
    .in_strm_dn      (in_strm_dn),
    .in_strm_data    (in_strm_data),
    .out_addr        (out_addr),
    .out_ch_data     (out_ch_data),
    .out_frame_valid (out_frame_valid),
    .out_decim_valid (out_decim_valid),
    .out_overrun     (out_overrun),
    .out_er_data     (out_er_data),
    .out_diag_er     (out_diag_er)
  );

  always #5 clk = ~clk;

  // RAM model: channel words derived from seed/step, diagnostic word at its own address.
  assign in_strm_data = (out_addr == ADDR_W'(DIAG_ADDR)) ? diag_word
                                                         : ram_seed + 24'(out_addr) * ram_step;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [23:0] seed, input logic [23:0] step);
    logic [FW-1:0] f;
    logic [23:0]   w;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w = seed + 24'(CH_BASE + i) * step;
      f[i*DATA_W +: DATA_W] = w[DATA_W-1:0];
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    in_mode = m;
    if (m == MODE_IDLE || m == 2'b11) exp_decim_cnt = 0;
  endtask

  task automatic push_frame(input logic [23:0] seed, input logic [23:0] step);
    exp_t e;
    e.data  = frame_of(seed, step);
    e.decim = (exp_decim_cnt == DECIM - 1);
    exp_decim_cnt = (exp_decim_cnt == DECIM - 1) ? 0 : exp_decim_cnt + 1;
    sb.push_back(e);
    last_exp = e.data;
  endtask

  task automatic pulse_dn();
    in_strm_dn = 1'b1;
    tick();
    in_strm_dn = 1'b0;
  endtask

  task automatic wait_publish();
    int n;
    n = 0;
    while (!out_frame_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("pub_seen", out_frame_valid, 1);
    n = 0;
    while (out_frame_valid && n < 10) begin
      tick();
      n++;
    end
    check_eq("pub_drop", out_frame_valid, 0);
  endtask

  // Publish monitor: pops the scoreboard on each strobe and checks strobe shape.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (out_frame_valid && !prev_valid) begin
        n_pub++;
        check_eq("sb_nonempty", 160'(sb.size() != 0), 160'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("pub_ch_data", out_ch_data, mon_e.data);
          check_eq("pub_decim", out_decim_valid, mon_e.decim);
        end
        if (out_decim_valid) n_dec_hi++;
        else n_dec_lo++;
      end
      if (out_frame_valid) begin
        vlen++;
      end else if (vlen != 0) begin
        check_eq("valid_len", 160'(vlen), 160'(VALID_HOLD));
        vlen = 0;
      end
      if (out_decim_valid) check_eq("decim_with_frame", out_frame_valid, 1);
      prev_valid = out_frame_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset overrides an active stream request.
    in_reset   = 1'b1;
    in_mode    = MODE_STREAM;
    in_strm_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_outputs", {out_addr, out_ch_data, out_frame_valid, out_decim_valid,
                               out_overrun, out_er_data, out_diag_er}, '0);
      check_eq("rst_state", dut.state, S_IDLE);
    end
    in_reset   = 1'b0;
    in_strm_dn = 1'b0;
    set_mode(MODE_STREAM);
    tick();

    // Single frame with fixed data and edge-accurate timing.
    ram_seed = 24'hA00000;
    ram_step = 24'h000001;
    push_frame(ram_seed, ram_step);
    pulse_dn();
    check_eq("addr_k0", out_addr, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k <= NUM_CH * RD_LAT)
        check_eq($sformatf("addr_k%0d", k), out_addr,
                 (k < NUM_CH * RD_LAT) ? k / RD_LAT : NUM_CH - 1);
      check_eq($sformatf("fv_k%0d", k), out_frame_valid, (k == 13 || k == 14));
    end
    single_exp = '0;
    for (int i = 0; i < NUM_CH; i++) single_exp[i*DATA_W +: DATA_W] = 22'h200000 + 22'(i);
    check_eq("single_ch_data", out_ch_data, single_exp);

    // Decimation across 26 back-to-back frames.
    set_mode(MODE_IDLE);
    tick();
    set_mode(MODE_STREAM);
    tick();
    n_dec_hi = 0;
    n_dec_lo = 0;
    for (int f = 1; f <= 26; f++) begin
      ram_seed = 24'($urandom);
      ram_step = 24'($urandom);
      push_frame(ram_seed, ram_step);
      pulse_dn();
      wait_publish();
    end
    check_eq("decim_hi_count", 160'(n_dec_hi), 160'(2));
    check_eq("decim_lo_count", 160'(n_dec_lo), 160'(24));

    // Overrun: second request 4 cycles into FETCH is dropped and flagged.
    set_mode(MODE_IDLE);
    tick();
    check_eq("overrun_clear0", out_overrun, 0);
    set_mode(MODE_STREAM);
    tick();
    pub0     = n_pub;
    ram_seed = 24'h0F0F0F;
    ram_step = 24'h111111;
    push_frame(ram_seed, ram_step);
    pulse_dn();
    repeat (3) tick();
    in_strm_dn = 1'b1;
    tick();
    in_strm_dn = 1'b0;
    check_eq("overrun_set", out_overrun, 1);
    wait_publish();
    repeat (20) tick();
    check_eq("overrun_one_pub", 160'(n_pub - pub0), 160'(1));
    check_eq("overrun_sticky", out_overrun, 1);
    set_mode(MODE_IDLE);
    tick();
    check_eq("overrun_cleared", out_overrun, 0);
    check_eq("ch_data_held_idle", out_ch_data, last_exp);

    // Diagnostics: clean word, error word, and bits above the diag field ignored.
    diag_word = 24'h000000;
    set_mode(MODE_DIAG);
    tick();
    check_eq("diag_addr", out_addr, DIAG_ADDR);
    check_eq("diag_pending", out_diag_er, DIAG_PEND);
    repeat (3) tick();
    check_eq("diag0_data", out_er_data, 14'h0000);
    check_eq("diag0_er", out_diag_er, DIAG_OK);
    set_mode(MODE_IDLE);
    tick();
    check_eq("diag_cleared", out_diag_er, DIAG_PEND);
    diag_word = 24'h002001;
    set_mode(MODE_DIAG);
    repeat (4) tick();
    check_eq("diag1_data", out_er_data, 14'h2001);
    check_eq("diag1_er", out_diag_er, DIAG_ERR);
    set_mode(MODE_IDLE);
    tick();
    diag_word = 24'hFFC000;
    set_mode(MODE_DIAG);
    repeat (4) tick();
    check_eq("diag2_data", out_er_data, 14'h0000);
    check_eq("diag2_er", out_diag_er, DIAG_OK);

    // Abort: switch to diagnostics on the third FETCH capture.
    set_mode(MODE_IDLE);
    tick();
    set_mode(MODE_STREAM);
    tick();
    pub0      = n_pub;
    ram_seed  = 24'h123456;
    ram_step  = 24'h010203;
    diag_word = 24'h002001;
    pulse_dn();
    repeat (4) tick();
    check_eq("abort_addr", out_addr, 2);
    tick();
    set_mode(MODE_DIAG);
    tick();
    check_eq("abort_fv", out_frame_valid, 0);
    repeat (4) tick();
    check_eq("abort_diag_data", out_er_data, 14'h2001);
    check_eq("abort_diag_er", out_diag_er, DIAG_ERR);
    check_eq("abort_ch_data", out_ch_data, last_exp);
    repeat (20) tick();
    check_eq("abort_no_pub", 160'(n_pub - pub0), 160'(0));
    check_eq("sb_drained", 160'(sb.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
